cmd_sequencer: RTL and testbench
================================

Name: cmd_sequencer

Overview:
Parametrised command sequencer feeding the SDRAM controller (ctrl) with a programmable list of {command, address} entries. It starts on the rising edge of the controller's init-complete flag. It issues each entry with a valid/ready handshake and waits for the controller's done pulse before advancing. It supports run-time programming, variable sequence length, loop mode, abort and a per-command timeout. It replaces the fixed-length, file-loaded command source.

Parameters:
CMD_W, 4, command opcode width
ADDR_W, 22, address field width per entry
DEPTH, 16, table entries (power of 2); IDX_W = clog2(DEPTH)
TIMEOUT, 1024, max cycles in WAIT_DONE before error (>=2); counter width clog2(TIMEOUT)
NOP_CMD, 4'b0111, opcode driven on cmd when cmd_valid=0

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
init_comp  in  1  controller init complete (level); rising edge starts a sequence
cmd_done  in  1  controller finished current command (1-cycle pulse)
cmd_ready  in  1  controller can accept a command
cmd_valid  out  1  command/address valid
cmd  out  CMD_W  opcode; NOP_CMD when cmd_valid=0
cmd_addr  out  ADDR_W  address for cmd; 0 when cmd_valid=0
cmd_idx  out  IDX_W  index of entry being issued/awaited
seq_len  in  IDX_W+1  number of entries to run (1..DEPTH), sampled at start
loop_en  in  1  restart at entry 0 after last entry, sampled at start
abort  in  1  synchronous abort to IDLE
cfg_we  in  1  table write strobe
cfg_idx  in  IDX_W  table write index
cfg_cmd  in  CMD_W  table write opcode
cfg_addr  in  ADDR_W  table write address
busy  out  1  sequence in progress
seq_done  out  1  1-cycle pulse on normal completion
timeout_err  out  1  sticky; set on timeout, cleared at next start

Behaviour:
- Reset (rst=1, async): state=IDLE; cmd_valid=0, cmd=NOP_CMD, cmd_addr=0, cmd_idx=0, busy=0, seq_done=0, timeout_err=0, init edge register=0. Table contents are undefined after reset and are not cleared.
- All outputs are registered. Table is a DEPTH x (CMD_W+ADDR_W) register array with a synchronous write port. cfg_we is ignored while busy=1.
- start = init_comp & ~init_q, where init_q is init_comp registered. Starts are taken only in IDLE. Edges seen in other states are dropped, not queued.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE -> start with seq_len in 1..DEPTH: latch len and loop; idx=0; clear timeout_err. Next cycle is ISSUE with busy=1 and cmd_valid=1. Latency from start cycle to cmd_valid high is 1 clk.
- IDLE -> start with seq_len=0 or >DEPTH: stay in IDLE and pulse seq_done next cycle. No command is issued.
- ISSUE: cmd_valid=1 and cmd/cmd_addr=table[idx], both held stable until cmd_ready. The cycle with cmd_valid & cmd_ready is the transfer. The next cycle is WAIT_DONE with cmd_valid=0 and the timer cleared. cmd_done in ISSUE is ignored.
- WAIT_DONE: timer increments each cycle.
  - cmd_done, idx < len-1: idx+1, go to ISSUE.
  - cmd_done, idx = len-1, loop=1: idx=0, go to ISSUE. seq_done is not pulsed.
  - cmd_done, idx = len-1, loop=0: go to IDLE, busy=0, seq_done=1 for one cycle.
  - Timer reaches TIMEOUT-1 with no cmd_done: timeout_err=1, go to IDLE, busy=0, no seq_done.
  - cmd_done on the same cycle as the timeout: done wins.
- abort=1 in any state: next cycle is IDLE, cmd_valid=0, busy=0, no seq_done, timeout_err unchanged. abort has priority over every other transition, including a transfer and cmd_done on the same cycle.
- cfg_we to index k with busy=0 takes effect for the next start.
- rst asserted mid-sequence returns everything to reset values immediately. After release, a new sequence needs a new init_comp rising edge; a level already high does not restart.

Decomposition:
- Shared package sdram_pkg: the SDRAM opcode constants (NOP, ACTIVE, READ, WRITE, PRECHARGE, REFRESH, LOAD_MODE), the CMD_W/ADDR_W defaults, and the sequencer state encoding.
- One natural sub-module: cmd_table, a DEPTH-entry register file with a synchronous write port and an asynchronous read port on idx. The FSM, timer and edge detect stay in cmd_sequencer.

Test Plan:
- Program 3 entries {ACTIVE,0x100},{WRITE,0x104},{PRECHARGE,0x0}; seq_len=3, loop_en=0; raise init_comp; cmd_ready=1, cmd_done 3 clk after each transfer -> the 3 commands are issued in order with the matching cmd_idx 0,1,2. seq_done pulses once, 1 clk after the third cmd_done. busy=0 afterwards.
- Same program, cmd_ready held low 5 clk -> cmd/cmd_addr/cmd_valid are stable all 5 cycles and only one transfer occurs.
- seq_len=2, loop_en=1, cmd_done every command -> idx sequence 0,1,0,1,...; seq_done never pulses. abort -> IDLE next clk, cmd_valid=0, busy=0.
- TIMEOUT=16, no cmd_done after the first transfer -> timeout_err=1 exactly 16 clk after entering WAIT_DONE, state IDLE, no seq_done. The next start clears timeout_err.
- seq_len=0 and init_comp rising -> seq_done pulses after 1 clk and cmd_valid never goes high. init_comp held high with no new edge -> no restart.
- Assert rst mid-WAIT_DONE -> all outputs return to reset values asynchronously. cfg_we pulsed while busy -> table unchanged, confirmed by rerunning the sequence.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: opcode constants, default field widths and the
// command sequencer state encoding.
// Opcodes use the {RAS_n, CAS_n, WE_n} plus spare-MSB encoding of the controller.
package sdram_pkg;

    // Default field widths used by the sequencer and its table.
    localparam int CMD_W_DEF  = 4;
    localparam int ADDR_W_DEF = 22;

    // SDRAM command opcodes.
    localparam logic [3:0] OP_LOAD_MODE = 4'b0000;
    localparam logic [3:0] OP_REFRESH   = 4'b0001;
    localparam logic [3:0] OP_PRECHARGE = 4'b0010;
    localparam logic [3:0] OP_ACTIVE    = 4'b0011;
    localparam logic [3:0] OP_WRITE     = 4'b0100;
    localparam logic [3:0] OP_READ      = 4'b0101;
    localparam logic [3:0] OP_NOP       = 4'b0111;

    // Sequencer states.
    typedef enum logic [1:0] {
        SEQ_IDLE      = 2'd0,
        SEQ_ISSUE     = 2'd1,
        SEQ_WAIT_DONE = 2'd2
    } seq_state_t;

    // A sequence length is usable only when it names at least one entry and
    // does not run past the end of the table.
    function automatic bit len_in_range(input int len, input int depth);
        return (len >= 1) && (len <= depth);
    endfunction

endpackage

// File: rtl/cmd_table.sv
// Command table: DEPTH x {cmd, addr} register file, sync write, async read.
// Latency: write visible on the cycle after the strobe; read is combinational.
// Backpressure: none; writes are always accepted when we_i is high.
// Ports: clk; we_i/wr_idx_i/wr_cmd_i/wr_addr_i write port;
//        rd_idx_i read index; rd_cmd_o/rd_addr_o read data.
module cmd_table
    import sdram_pkg::*;
#(
    parameter int CMD_W  = CMD_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [CMD_W-1:0]  wr_cmd_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [CMD_W-1:0]  rd_cmd_o,
    output logic [ADDR_W-1:0] rd_addr_o
);

    // Contents are deliberately not reset: software programs the table
    // before the first start.
    logic [CMD_W+ADDR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= {wr_cmd_i, wr_addr_i};
        end
    end

    assign {rd_cmd_o, rd_addr_o} = mem_q[rd_idx_i];

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: replays a programmed {cmd, addr} list into the SDRAM
// controller on each init_comp rising edge, one command per cmd_done.
// Latency: start edge -> cmd_valid in 1 clk; cmd_done -> next cmd_valid in 1 clk.
// Backpressure: cmd/cmd_addr held stable while cmd_valid & ~cmd_ready.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   init_comp              controller init complete; rising edge starts a run
//   cmd_valid/cmd_ready    command handshake; cmd/cmd_addr/cmd_idx payload
//   cmd_done               controller finished the outstanding command
//   seq_len, loop_en       run length and loop mode, sampled at start
//   abort                  return to IDLE on the next clock
//   cfg_we/idx/cmd/addr    table write port, ignored while busy
//   busy, seq_done         run in progress / normal completion pulse
//   timeout_err            sticky per-command timeout flag
module cmd_sequencer
    import sdram_pkg::*;
#(
    parameter int              CMD_W   = CMD_W_DEF,
    parameter int              ADDR_W  = ADDR_W_DEF,
    parameter int              DEPTH   = 16,
    parameter int              TIMEOUT = 1024,
    parameter logic [CMD_W-1:0] NOP_CMD = CMD_W'(OP_NOP),
    localparam int             IDX_W   = $clog2(DEPTH),
    localparam int             TMR_W   = $clog2(TIMEOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_comp,
    input  logic              cmd_done,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [CMD_W-1:0]  cmd,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [IDX_W-1:0]  cmd_idx,
    input  logic [IDX_W:0]    seq_len,
    input  logic              loop_en,
    input  logic              abort,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [CMD_W-1:0]  cfg_cmd,
    input  logic [ADDR_W-1:0] cfg_addr,
    output logic              busy,
    output logic              seq_done,
    output logic              timeout_err
);

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]   LEN_ONE  = (IDX_W+1)'(1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    seq_state_t        state_q, state_d;
    logic              init_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W:0]    len_q, len_d;
    logic              loop_q, loop_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;

    logic              cmd_valid_q, cmd_valid_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              busy_q, busy_d;
    logic              seq_done_q, seq_done_d;
    logic              timeout_err_q, timeout_err_d;

    logic              start;
    logic              xfer;
    logic              last_entry;
    logic              tmr_expired;
    logic [CMD_W-1:0]  tbl_cmd;
    logic [ADDR_W-1:0] tbl_addr;

    // ------------------------------------------------------------------
    // Command table. The read port follows the next index so the registered
    // cmd/cmd_addr already hold the entry on the first ISSUE cycle.
    // ------------------------------------------------------------------
    cmd_table #(
        .CMD_W  (CMD_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk       (clk),
        .we_i      (cfg_we & ~busy_q),
        .wr_idx_i  (cfg_idx),
        .wr_cmd_i  (cfg_cmd),
        .wr_addr_i (cfg_addr),
        .rd_idx_i  (idx_d),
        .rd_cmd_o  (tbl_cmd),
        .rd_addr_o (tbl_addr)
    );

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    // Only a fresh edge starts a run; a level that is already high when the
    // FSM returns to IDLE is ignored.
    assign start       = init_comp & ~init_q;
    assign xfer        = (state_q == SEQ_ISSUE) & cmd_ready;
    assign last_entry  = ({1'b0, idx_q} == (len_q - LEN_ONE));
    assign tmr_expired = (tmr_q == TMR_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SEQ_IDLE;
            init_q        <= 1'b0;
            idx_q         <= '0;
            len_q         <= '0;
            loop_q        <= 1'b0;
            tmr_q         <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_q         <= NOP_CMD;
            cmd_addr_q    <= '0;
            busy_q        <= 1'b0;
            seq_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_q        <= init_comp;
            idx_q         <= idx_d;
            len_q         <= len_d;
            loop_q        <= loop_d;
            tmr_q         <= tmr_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_q         <= cmd_d;
            cmd_addr_q    <= cmd_addr_d;
            busy_q        <= busy_d;
            seq_done_q    <= seq_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        loop_d        = loop_q;
        tmr_d         = tmr_q;
        seq_done_d    = 1'b0;
        timeout_err_d = timeout_err_q;

        if (abort) begin
            // Abort beats a same-cycle transfer or cmd_done and leaves the
            // error flag alone so software can still inspect it.
            state_d = SEQ_IDLE;
        end else begin
            unique case (state_q)
                SEQ_IDLE: begin
                    if (start) begin
                        if (len_in_range(int'(seq_len), DEPTH)) begin
                            state_d       = SEQ_ISSUE;
                            len_d         = seq_len;
                            loop_d        = loop_en;
                            idx_d         = '0;
                            timeout_err_d = 1'b0;
                        end else begin
                            // Empty or oversized run completes immediately.
                            seq_done_d = 1'b1;
                        end
                    end
                end

                SEQ_ISSUE: begin
                    // cmd_done here belongs to nothing outstanding: ignored.
                    if (xfer) begin
                        state_d = SEQ_WAIT_DONE;
                        tmr_d   = '0;
                    end
                end

                SEQ_WAIT_DONE: begin
                    tmr_d = tmr_q + TMR_ONE;
                    // cmd_done is checked first so it wins over a
                    // same-cycle timeout.
                    if (cmd_done) begin
                        if (!last_entry) begin
                            idx_d   = idx_q + IDX_ONE;
                            state_d = SEQ_ISSUE;
                        end else if (loop_q) begin
                            idx_d   = '0;
                            state_d = SEQ_ISSUE;
                        end else begin
                            state_d    = SEQ_IDLE;
                            seq_done_d = 1'b1;
                        end
                    end else if (tmr_expired) begin
                        state_d       = SEQ_IDLE;
                        timeout_err_d = 1'b1;
                    end
                end

                default: begin
                    state_d = SEQ_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output next values, derived from the next state so every output is
    // a flop. The table cannot change while busy, so re-reading it every
    // ISSUE cycle keeps cmd/cmd_addr stable under backpressure.
    // ------------------------------------------------------------------
    always_comb begin
        cmd_valid_d = (state_d == SEQ_ISSUE);
        busy_d      = (state_d != SEQ_IDLE);
        cmd_d       = NOP_CMD;
        cmd_addr_d  = '0;
        if (cmd_valid_d) begin
            cmd_d      = tbl_cmd;
            cmd_addr_d = tbl_addr;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd         = cmd_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_idx     = idx_q;
    assign busy        = busy_q;
    assign seq_done    = seq_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Testbench for cmd_sequencer: directed scenarios plus randomized runs,
// checked against a table-level reference model kept in the bench.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cmd_sequencer;
    import sdram_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_comp;
    logic        cmd_done;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic [21:0] cmd_addr;
    logic [3:0]  cmd_idx;
    logic [4:0]  seq_len;
    logic        loop_en;
    logic        abort;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic [3:0]  cfg_cmd;
    logic [21:0] cfg_addr;
    logic        busy;
    logic        seq_done;
    logic        timeout_err;

    // Reference model: what the table should hold.
    logic [3:0]  m_cmd  [DEPTH];
    logic [21:0] m_addr [DEPTH];
    logic [3:0]  ops    [7];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    cmd_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .init_comp   (init_comp),
        .cmd_done    (cmd_done),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_addr    (cmd_addr),
        .cmd_idx     (cmd_idx),
        .seq_len     (seq_len),
        .loop_en     (loop_en),
        .abort       (abort),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_cmd     (cfg_cmd),
        .cfg_addr    (cfg_addr),
        .busy        (busy),
        .seq_done    (seq_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input int k, input logic [3:0] c, input logic [21:0] a, input bit upd);
        cfg_we   = 1'b1;
        cfg_idx  = 4'(k);
        cfg_cmd  = c;
        cfg_addr = a;
        tick();
        cfg_we   = 1'b0;
        if (upd) begin
            m_cmd[k]  = c;
            m_addr[k] = a;
        end
    endtask

    // Produces a fresh rising edge on init_comp; returns on the falling edge
    // after the start cycle.
    task automatic start(input int len, input bit lp);
        seq_len   = 5'(len);
        loop_en   = lp;
        init_comp = 1'b0;
        tick();
        init_comp = 1'b1;
        tick();
    endtask

    // Acts as the controller for one command: checks the presented entry,
    // holds off cmd_ready, accepts, then returns cmd_done after done_dly.
    task automatic serve(input int i, input int rdy_dly, input int done_dly, input bit last);
        chk("issue_valid", 32'(cmd_valid), 32'd1);
        chk("issue_idx",   32'(cmd_idx),   32'(i));
        chk("issue_cmd",   32'(cmd),       32'(m_cmd[i]));
        chk("issue_addr",  32'(cmd_addr),  32'(m_addr[i]));
        chk("issue_busy",  32'(busy),      32'd1);
        for (int k = 0; k < rdy_dly; k++) begin
            cmd_ready = 1'b0;
            tick();
            chk("hold_valid", 32'(cmd_valid), 32'd1);
            chk("hold_cmd",   32'(cmd),       32'(m_cmd[i]));
            chk("hold_addr",  32'(cmd_addr),  32'(m_addr[i]));
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("wait_valid", 32'(cmd_valid), 32'd0);
        chk("wait_cmd",   32'(cmd),       32'(OP_NOP));
        chk("wait_addr",  32'(cmd_addr),  32'd0);
        chk("wait_idx",   32'(cmd_idx),   32'(i));
        for (int k = 1; k < done_dly; k++) tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("after_done_seq_done", 32'(seq_done), 32'(last));
        chk("after_done_busy",     32'(busy),     32'(!last));
    endtask

    initial begin
        ops[0] = OP_LOAD_MODE; ops[1] = OP_REFRESH; ops[2] = OP_PRECHARGE;
        ops[3] = OP_ACTIVE;    ops[4] = OP_WRITE;   ops[5] = OP_READ;
        ops[6] = OP_NOP;
        rst = 1'b1; init_comp = 1'b0; cmd_done = 1'b0; cmd_ready = 1'b0;
        seq_len = '0; loop_en = 1'b0; abort = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_cmd = '0; cfg_addr = '0;

        // ---- reset values ----
        tick();
        chk("rst_valid", 32'(cmd_valid),   32'd0);
        chk("rst_cmd",   32'(cmd),         32'(OP_NOP));
        chk("rst_addr",  32'(cmd_addr),    32'd0);
        chk("rst_idx",   32'(cmd_idx),     32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(seq_done),    32'd0);
        chk("rst_err",   32'(timeout_err), 32'd0);
        rst = 1'b0;
        tick();

        // ---- basic three-command run ----
        cfg_write(0, OP_ACTIVE,    22'h100, 1'b1);
        cfg_write(1, OP_WRITE,     22'h104, 1'b1);
        cfg_write(2, OP_PRECHARGE, 22'h000, 1'b1);
        start(3, 1'b0);
        serve(0, 0, 3, 1'b0);
        serve(1, 0, 3, 1'b0);
        serve(2, 0, 3, 1'b1);
        tick();
        chk("t1_done_once", 32'(seq_done), 32'd0);
        chk("t1_idle_busy", 32'(busy),     32'd0);

        // ---- backpressure: ready low for 5 cycles ----
        start(3, 1'b0);
        serve(0, 5, 3, 1'b0);
        serve(1, 0, 2, 1'b0);
        serve(2, 2, 1, 1'b1);
        tick();

        // ---- loop mode, then abort during a transfer ----
        start(2, 1'b1);
        for (int n = 0; n < 5; n++)
            serve(n % 2, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 1'b0);
        abort = 1'b1; cmd_ready = 1'b1;
        tick();
        abort = 1'b0; cmd_ready = 1'b0;
        chk("abort_valid", 32'(cmd_valid), 32'd0);
        chk("abort_busy",  32'(busy),      32'd0);
        chk("abort_done",  32'(seq_done),  32'd0);
        tick();
        chk("abort_stay_busy", 32'(busy), 32'd0);

        // ---- abort beats cmd_done in WAIT_DONE ----
        start(2, 1'b1);
        serve(0, 0, 1, 1'b0);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        abort = 1'b1; cmd_done = 1'b1;
        tick();
        abort = 1'b0; cmd_done = 1'b0;
        chk("abort_wait_valid", 32'(cmd_valid), 32'd0);
        chk("abort_wait_busy",  32'(busy),      32'd0);
        chk("abort_wait_done",  32'(seq_done),  32'd0);

        // ---- timeout: no cmd_done after the transfer ----
        start(1, 1'b0);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            chk("to_pending_err",  32'(timeout_err), 32'd0);
            chk("to_pending_busy", 32'(busy),        32'd1);
        end
        tick();
        chk("to_err",   32'(timeout_err), 32'd1);
        chk("to_busy",  32'(busy),        32'd0);
        chk("to_done",  32'(seq_done),    32'd0);
        chk("to_valid", 32'(cmd_valid),   32'd0);
        tick();
        chk("to_sticky", 32'(timeout_err), 32'd1);

        // ---- next start clears the flag; done on the timeout cycle wins ----
        start(1, 1'b0);
        chk("restart_clr_err", 32'(timeout_err), 32'd0);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) tick();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("race_done", 32'(seq_done),    32'd1);
        chk("race_err",  32'(timeout_err), 32'd0);
        chk("race_busy", 32'(busy),        32'd0);

        // ---- out-of-range lengths complete immediately ----
        start(0, 1'b0);
        chk("len0_done",  32'(seq_done),  32'd1);
        chk("len0_valid", 32'(cmd_valid), 32'd0);
        chk("len0_busy",  32'(busy),      32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("level_no_restart_valid", 32'(cmd_valid), 32'd0);
            chk("level_no_restart_done",  32'(seq_done),  32'd0);
        end
        start(DEPTH + 1, 1'b0);
        chk("len17_done",  32'(seq_done),  32'd1);
        chk("len17_valid", 32'(cmd_valid), 32'd0);

        // ---- asynchronous reset in WAIT_DONE ----
        start(3, 1'b0);
        serve(0, 0, 1, 1'b0);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        tick();
        #2 rst = 1'b1; init_comp = 1'b0;
        #1;
        chk("arst_valid", 32'(cmd_valid),   32'd0);
        chk("arst_cmd",   32'(cmd),         32'(OP_NOP));
        chk("arst_addr",  32'(cmd_addr),    32'd0);
        chk("arst_idx",   32'(cmd_idx),     32'd0);
        chk("arst_busy",  32'(busy),        32'd0);
        chk("arst_err",   32'(timeout_err), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_idle", 32'(busy), 32'd0);

        // ---- table writes while busy are dropped ----
        start(3, 1'b0);
        cfg_write(0, OP_REFRESH, 22'h3FFFFF, 1'b0);
        serve(0, 1, 1, 1'b0);
        cfg_write(2, OP_READ, 22'h2AAAA, 1'b0);
        serve(1, 0, 1, 1'b0);
        serve(2, 0, 1, 1'b1);
        tick();
        start(3, 1'b0);
        serve(0, 0, 1, 1'b0);
        serve(1, 0, 1, 1'b0);
        serve(2, 0, 1, 1'b1);
        tick();

        // ---- randomized runs against the table model ----
        for (int r = 0; r < 8; r++) begin
            int nw;
            int len;
            nw = int'($urandom_range(1, 6));
            for (int w = 0; w < nw; w++)
                cfg_write(int'($urandom_range(0, DEPTH - 1)), ops[$urandom_range(0, 6)],
                          22'($urandom), 1'b1);
            len = int'($urandom_range(1, DEPTH));
            start(len, 1'b0);
            for (int i = 0; i < len; i++)
                serve(i, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), i == len - 1);
            tick();
            chk("rand_done_once", 32'(seq_done), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
